branch_predictor: RTL

Parametrised successor to the static branch unit. It holds a direct-mapped branch history table (BHT) of 2-bit saturating counters and a direct-mapped branch target buffer (BTB), and supplies a taken/target prediction to the IF stage every cycle. It also resolves branches and jumps in EX, generates the redirect and IF/ID and ID/EX flushes on a misprediction, and trains both tables.

---
 rtl/branch_predictor.sv | 107 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit BHT + direct-mapped BTB fetch predictor with EX-stage resolve, redirect and training.
// Ports: clk, rst_n (async, active-low); if_pc -> if_pred_taken/if_pred_target (combinational lookup);
// ex_* resolve inputs -> pc_src, redirect_pc, flush_ifid, flush_idex (combinational);
// perf_branches/perf_mispredicts exist only when BP_PERF_CNT_EN is defined.
module branch_predictor #(
   parameter int WORD_SIZE      = 32,
   parameter int BHT_INDEX_BITS = 6,
   parameter int BTB_INDEX_BITS = 4,
   parameter int PERF_CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] if_pc,
   output logic                 if_pred_taken,
   output logic [WORD_SIZE-1:0] if_pred_target,
   input  logic                 ex_valid,
   input  logic                 ex_branch,
   input  logic                 ex_jump,
   input  logic                 ex_cond,
   input  logic [WORD_SIZE-1:0] ex_pc,
   input  logic [WORD_SIZE-1:0] ex_target,
   input  logic                 ex_pred_taken,
   input  logic [WORD_SIZE-1:0] ex_pred_target,
   output logic                 pc_src,
   output logic [WORD_SIZE-1:0] redirect_pc,
   output logic                 flush_ifid,
   output logic                 flush_idex
`ifdef BP_PERF_CNT_EN
   ,
   output logic [PERF_CNT_WIDTH-1:0] perf_branches,
   output logic [PERF_CNT_WIDTH-1:0] perf_mispredicts
`endif
);
   localparam int BHT_N = 1 << BHT_INDEX_BITS;
   localparam int BTB_N = 1 << BTB_INDEX_BITS;
   localparam int TAG_W = WORD_SIZE - BTB_INDEX_BITS - 2;
   logic [1:0]           bht [BHT_N];
   logic [BTB_N-1:0]     btb_valid;
   logic [BTB_N-1:0]     btb_jump;
   logic [TAG_W-1:0]     btb_tag [BTB_N];
   logic [WORD_SIZE-1:0] btb_target [BTB_N];
   logic [BHT_INDEX_BITS-1:0] if_bi, ex_bi;
   logic [BTB_INDEX_BITS-1:0] if_ti, ex_ti;
   logic [TAG_W-1:0]          if_tag, ex_tag;
   logic       hit, is_cf, actual_taken, alias_mis, mispredict, bht_we, btb_we;
   logic [1:0] cnt, cnt_next;
   logic       unused_ok;
   assign unused_ok = ^if_pc[1:0];
   always_comb begin
      if_bi          = if_pc[BHT_INDEX_BITS+1:2];
      if_ti          = if_pc[BTB_INDEX_BITS+1:2];
      if_tag         = if_pc[WORD_SIZE-1:BTB_INDEX_BITS+2];
      ex_bi          = ex_pc[BHT_INDEX_BITS+1:2];
      ex_ti          = ex_pc[BTB_INDEX_BITS+1:2];
      ex_tag         = ex_pc[WORD_SIZE-1:BTB_INDEX_BITS+2];
      hit            = btb_valid[if_ti] && (btb_tag[if_ti] == if_tag);
      // jumps in the BTB predict taken regardless of the direction counter
      if_pred_taken  = hit && (btb_jump[if_ti] || bht[if_bi][1]);
      if_pred_target = btb_target[if_ti];
      is_cf          = ex_branch | ex_jump;
      actual_taken   = ex_jump | (ex_branch & ex_cond);
      // a BTB hit on a non-control-flow instruction is a stale or aliased entry
      alias_mis      = ex_valid & ~is_cf & ex_pred_taken;
      mispredict     = alias_mis | (ex_valid & is_cf &
                       ((actual_taken != ex_pred_taken) | (actual_taken & (ex_target != ex_pred_target))));
      pc_src         = mispredict;
      flush_ifid     = mispredict;
      flush_idex     = mispredict;
      redirect_pc    = !mispredict ? '0 : actual_taken ? ex_target : ex_pc + WORD_SIZE'(4);
      cnt            = bht[ex_bi];
      cnt_next       = ex_cond ? (cnt == 2'd3 ? cnt : cnt + 2'd1) : (cnt == 2'd0 ? cnt : cnt - 2'd1);
      bht_we         = ex_valid & ex_branch;
      btb_we         = ex_valid & actual_taken;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_N; i++) bht[i] <= 2'd1;
         btb_valid <= '0;
      end else begin
         if (bht_we) bht[ex_bi] <= cnt_next;
         if (btb_we) btb_valid[ex_ti] <= 1'b1;
         else if (alias_mis) btb_valid[ex_ti] <= 1'b0;
      end
   end
   // entry payload needs no reset: it is only observed through the valid bit
   always_ff @(posedge clk) begin
      if (btb_we) begin
         btb_tag[ex_ti]    <= ex_tag;
         btb_target[ex_ti] <= ex_target;
         btb_jump[ex_ti]   <= ex_jump;
      end
   end
`ifdef BP_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (ex_valid & is_cf) perf_branches <= perf_branches + 1'b1;
         if (mispredict) perf_mispredicts <= perf_mispredicts + 1'b1;
      end
   end
`else
   logic [PERF_CNT_WIDTH-1:0] unused_perf;
   assign unused_perf = '0;
`endif
endmodule
